// File: rtl/bt_key_decoder.sv
// Bluetooth key-frame decoder: parses HDR / payload / ~payload byte triples from the UART
// and presents validated key codes to the controller with a one-cycle ready pulse.
module bt_key_decoder #(
   parameter logic [7:0]  HDR_BYTE       = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [2:0] key_val,
   output logic       press,
   output logic       ready,
   output logic       frame_err
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {StIdle, StGotHdr, StGotPay} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      pay_q, pay_d;
   logic [2:0]      key_q, key_d;
   logic            press_q, press_d;
   logic            ready_q, ready_d;
   logic            err_q, err_d;
   logic            timed_out;

   // A byte arriving on the cycle the count saturates takes priority over the timeout.
   assign timed_out = !rx_valid && (cnt_q == CntMax);

   always_comb begin
      state_d = state_q;
      pay_d   = pay_q;
      key_d   = key_q;
      press_d = press_q;
      ready_d = 1'b0;
      err_d   = 1'b0;

      if (rx_valid || (state_q == StIdle)) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end

      unique case (state_q)
         StIdle: begin
            if (rx_valid && (rx_data == HDR_BYTE)) begin
               state_d = StGotHdr;
            end
         end
         StGotHdr: begin
            if (rx_valid) begin
               if (rx_data == HDR_BYTE) begin
                  state_d = StGotHdr;
               end else if (rx_data[6:3] != 4'b0000) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  pay_d   = rx_data;
                  state_d = StGotPay;
               end
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StGotPay: begin
            if (rx_valid) begin
               if (rx_data == ~pay_q) begin
                  key_d   = pay_q[2:0];
                  press_d = pay_q[7];
                  ready_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  err_d   = 1'b1;
                  state_d = (rx_data == HDR_BYTE) ? StGotHdr : StIdle;
               end
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         pay_q   <= '0;
         key_q   <= '0;
         press_q <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pay_q   <= pay_d;
         key_q   <= key_d;
         press_q <= press_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign key_val   = key_q;
   assign press     = press_q;
   assign ready     = ready_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_bt_key_decoder.sv
// Scoreboard bench for bt_key_decoder: a byte-buffer frame model queues expected events,
// and a monitor pops and compares them whenever ready or frame_err pulses.
module tb_bt_key_decoder;

   localparam int unsigned T   = 16;
   localparam logic [7:0]  HDR = 8'hA5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [2:0] key_val;
   logic       press, ready, frame_err;

   bt_key_decoder #(
      .HDR_BYTE      (HDR),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .key_val  (key_val),
      .press    (press),
      .ready    (ready),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_err;
      logic [2:0] key;
      logic       press;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] fr[$];
   int         gap = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [2:0] exp_key = 3'd0;
   logic       exp_press = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_ev(input logic is_err, input logic [7:0] pay);
      ev_t e;
      e.is_err = is_err;
      e.key    = pay[2:0];
      e.press  = pay[7];
      exp_q.push_back(e);
   endtask

   // Reference: fr holds the bytes of the frame gathered so far; gap counts idle cycles.
   task automatic model_step(input logic v, input logic [7:0] b);
      if (!v) begin
         if (fr.size() > 0) begin
            gap++;
            if (gap == T + 1) begin
               push_ev(1'b1, 8'h00);
               fr.delete();
            end
         end
         return;
      end
      gap = 0;
      if (fr.size() == 0) begin
         if (b == HDR) fr.push_back(b);
      end else if (fr.size() == 1) begin
         if (b != HDR) begin
            if (b[6:3] != 4'b0000) begin
               push_ev(1'b1, 8'h00);
               fr.delete();
            end else begin
               fr.push_back(b);
            end
         end
      end else begin
         if (b == ~fr[1]) begin
            push_ev(1'b0, fr[1]);
            fr.delete();
         end else begin
            push_ev(1'b1, 8'h00);
            fr.delete();
            if (b == HDR) fr.push_back(b);
         end
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] b);
      rx_valid = v;
      rx_data  = b;
      model_step(v, b);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      fr.delete();
      gap = 0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      exp_key   = 3'd0;
      exp_press = 1'b0;
   endtask

   // Monitor
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (!rst && (ready || frame_err)) begin
            check("ready_err_exclusive", int'(ready & frame_err), 0);
            if (exp_q.size() == 0) begin
               check("unexpected_event", {ready, frame_err}, 0);
            end else begin
               e = exp_q.pop_front();
               check("event_kind_is_err", int'(frame_err), int'(e.is_err));
               if (ready) begin
                  check("key_val", key_val, e.key);
                  check("press", press, e.press);
                  exp_key   = e.key;
                  exp_press = e.press;
               end else begin
                  check("key_val_held", key_val, exp_key);
                  check("press_held", press, exp_press);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] p, b;
      int         r, g;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_key_val", key_val, 0);
      check("rst_press", press, 0);
      check("rst_ready", ready, 0);
      check("rst_frame_err", frame_err, 0);
      @(posedge clk);
      #1;

      // Directed cases
      send(HDR); send(8'h84); send(8'h7B); idle(2);
      send(HDR); send(8'h04); send(8'hFB); idle(3);
      send(HDR); send(8'h02); send(8'hFD); idle(2);
      send(HDR); send(8'h82); send(8'h00); idle(2);
      send(HDR); send(8'h0A); idle(2);
      send(HDR); send(HDR); send(8'h83); send(8'h7C); idle(2);
      send(HDR); idle(T + 1); send(8'h02); send(8'hFD); idle(2);
      send(HDR); idle(T); send(8'h02); send(8'hFD); idle(2);
      send(HDR); send(8'h01); idle(T); send(8'hFE); idle(2);
      send(HDR); send(8'h82);
      do_reset();
      send(8'h7D); idle(2);
      @(negedge clk);
      check("mid_rst_key_val", key_val, 0);
      check("mid_rst_press", press, 0);
      @(posedge clk);
      #1;
      // Back-to-back identical frames
      send(HDR); send(8'h81); send(8'h7E);
      send(HDR); send(8'h81); send(8'h7E); idle(2);

      // Random mix
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         g = $urandom_range(0, 2);
         p = {1'($urandom_range(0, 1)), 4'b0000, 3'($urandom_range(0, 7))};
         if (r <= 4) begin
            send(HDR); idle(g); send(p); idle(g); send(~p);
         end else if (r == 5) begin
            send(HDR); send(p); send(~p ^ 8'($urandom_range(1, 255)));
         end else if (r == 6) begin
            b = 8'($urandom);
            b[6:3] = 4'hF;
            send(HDR); send(b);
         end else if (r == 7) begin
            send(HDR); send(HDR); send(p); send(~p);
         end else if (r == 8) begin
            repeat (3) send(8'($urandom));
         end else begin
            send(HDR); idle(T + $urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) send(p);
         end
         idle($urandom_range(0, 2));
      end

      idle(T + 4);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
